issue_queue: RTL and testbench

// Parametrised reservation station, the next generation of the single-FU RS. It sits between rename/dispatch and one FU.

---
 rtl/issue_queue.sv | 191 +++++++++++++++++++
 tb/tb_issue_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Reservation station for one FU: holds renamed uops, wakes operands from writeback
// broadcasts, issues the oldest ready uop and squashes on mispredict. Optional: ISSUE_QUEUE_BYPASS_EN.
module issue_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PREG_W = 7,
   parameter int unsigned ROB_W  = 5,
   parameter int unsigned NUM_WB = 2,
   parameter int unsigned IMM_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [6:0]                 disp_opcode,
   input  logic [PREG_W-1:0]          disp_pd,
   input  logic [PREG_W-1:0]          disp_ps1,
   input  logic [PREG_W-1:0]          disp_ps2,
   input  logic                       disp_ps1_rdy,
   input  logic                       disp_ps2_rdy,
   input  logic [IMM_W-1:0]           disp_imm,
   input  logic [ROB_W-1:0]           disp_rob_idx,
   input  logic [NUM_WB-1:0]          wb_valid,
   input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
   input  logic [ROB_W-1:0]           rob_head,
   input  logic                       flush,
   input  logic [ROB_W-1:0]           flush_rob_idx,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [6:0]                 iss_opcode,
   output logic [PREG_W-1:0]          iss_pd,
   output logic [PREG_W-1:0]          iss_ps1,
   output logic [PREG_W-1:0]          iss_ps2,
   output logic [IMM_W-1:0]           iss_imm,
   output logic [ROB_W-1:0]           iss_rob_idx,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
   logic [6:0]        opcode_q [DEPTH];
   logic [6:0]        opcode_d [DEPTH];
   logic [PREG_W-1:0] pd_q [DEPTH];
   logic [PREG_W-1:0] pd_d [DEPTH];
   logic [PREG_W-1:0] ps1_q [DEPTH];
   logic [PREG_W-1:0] ps1_d [DEPTH];
   logic [PREG_W-1:0] ps2_q [DEPTH];
   logic [PREG_W-1:0] ps2_d [DEPTH];
   logic [IMM_W-1:0]  imm_q [DEPTH];
   logic [IMM_W-1:0]  imm_d [DEPTH];
   logic [ROB_W-1:0]  rob_q [DEPTH];
   logic [ROB_W-1:0]  rob_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   logic              sel_found, free_found, iss_fire, new_r1, new_r2;
   logic [IDX_W-1:0]  sel_idx, free_idx;
   logic [ROB_W-1:0]  sel_age, age_i, flush_age;

   assign disp_ready = (count_q < CNT_W'(DEPTH));
   assign count      = count_q;
   assign iss_fire   = iss_valid & iss_ready;

   // Oldest ready entry by age relative to rob_head; strict compare keeps lowest index on ties
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      age_i     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_i = ROB_W'(rob_q[i] - rob_head);
         if (valid_q[i] && r1_q[i] && r2_q[i] && (!sel_found || age_i < sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = age_i;
         end
      end
   end

   always_comb begin
      iss_valid   = sel_found & ~flush;
      iss_opcode  = '0;
      iss_pd      = '0;
      iss_ps1     = '0;
      iss_ps2     = '0;
      iss_imm     = '0;
      iss_rob_idx = '0;
      if (iss_valid) begin
         iss_opcode  = opcode_q[sel_idx];
         iss_pd      = pd_q[sel_idx];
         iss_ps1     = ps1_q[sel_idx];
         iss_ps2     = ps2_q[sel_idx];
         iss_imm     = imm_q[sel_idx];
         iss_rob_idx = rob_q[sel_idx];
      end
   end

   // Only slots invalid in registered state are candidates, so a same-cycle issue is not reused
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      new_r1 = disp_ps1_rdy | (disp_ps1 == '0);
      new_r2 = disp_ps2_rdy | (disp_ps2 == '0);
`ifdef ISSUE_QUEUE_BYPASS_EN
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == disp_ps1) new_r1 = 1'b1;
         if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == disp_ps2) new_r2 = 1'b1;
      end
`endif
   end

   always_comb begin
      valid_d   = valid_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      opcode_d  = opcode_q;
      pd_d      = pd_q;
      ps1_d     = ps1_q;
      ps2_d     = ps2_q;
      imm_d     = imm_q;
      rob_d     = rob_q;
      count_d   = '0;
      flush_age = ROB_W'(flush_rob_idx - rob_head);
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == ps1_q[i]) r1_d[i] = 1'b1;
            if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == ps2_q[i]) r2_d[i] = 1'b1;
         end
      end
      if (iss_fire) begin
         valid_d[sel_idx] = 1'b0;
         r1_d[sel_idx]    = 1'b0;
         r2_d[sel_idx]    = 1'b0;
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && ROB_W'(rob_q[i] - rob_head) > flush_age) valid_d[i] = 1'b0;
         end
      end
      if (disp_valid && disp_ready && !flush) begin
         valid_d[free_idx]  = 1'b1;
         r1_d[free_idx]     = new_r1;
         r2_d[free_idx]     = new_r2;
         opcode_d[free_idx] = disp_opcode;
         pd_d[free_idx]     = disp_pd;
         ps1_d[free_idx]    = disp_ps1;
         ps2_d[free_idx]    = disp_ps2;
         imm_d[free_idx]    = disp_imm;
         rob_d[free_idx]    = disp_rob_idx;
      end
      for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(valid_d[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            opcode_q[i] <= '0;
            pd_q[i]     <= '0;
            ps1_q[i]    <= '0;
            ps2_q[i]    <= '0;
            imm_q[i]    <= '0;
            rob_q[i]    <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         count_q  <= count_d;
         opcode_q <= opcode_d;
         pd_q     <= pd_d;
         ps1_q    <= ps1_d;
         ps2_q    <= ps2_d;
         imm_q    <= imm_d;
         rob_q    <= rob_d;
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issues go into a scoreboard queue that a
// monitor drains on every issue handshake; state checks are made inline.
module tb_issue_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        disp_valid, disp_ready, disp_ps1_rdy, disp_ps2_rdy;
   logic [6:0]  disp_opcode, disp_pd, disp_ps1, disp_ps2;
   logic [31:0] disp_imm;
   logic [4:0]  disp_rob_idx, rob_head, flush_rob_idx;
   logic [1:0]  wb_valid;
   logic [13:0] wb_tag;
   logic        flush, iss_valid, iss_ready;
   logic [6:0]  iss_opcode, iss_pd, iss_ps1, iss_ps2;
   logic [31:0] iss_imm;
   logic [4:0]  iss_rob_idx;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   issue_queue dut (
      .clk(clk), .reset_n(reset_n),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
      .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
      .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy), .disp_imm(disp_imm),
      .disp_rob_idx(disp_rob_idx), .wb_valid(wb_valid), .wb_tag(wb_tag),
      .rob_head(rob_head), .flush(flush), .flush_rob_idx(flush_rob_idx),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
      .iss_pd(iss_pd), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_imm(iss_imm),
      .iss_rob_idx(iss_rob_idx), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Each handshake must match the oldest outstanding expectation {rob_idx, ps1}
   task automatic monitor();
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue actual rob=%0d ps1=%0d required none", iss_rob_idx, iss_ps1);
            end else begin
               e = exp_q.pop_front();
               check("issue_rob_ps1", {20'd0, iss_rob_idx, iss_ps1}, {20'd0, e});
               check("issue_opcode", {25'd0, iss_opcode}, {25'd0, 7'h33});
            end
         end
      end
   endtask

   task automatic dispatch(input logic [6:0] ps1, input logic r1, input logic [6:0] ps2,
                           input logic r2, input logic [4:0] rob);
      disp_valid   = 1'b1;
      disp_opcode  = 7'h33;
      disp_pd      = 7'd100;
      disp_ps1     = ps1;
      disp_ps1_rdy = r1;
      disp_ps2     = ps2;
      disp_ps2_rdy = r2;
      disp_imm     = 32'hdead0000 | 32'(rob);
      disp_rob_idx = rob;
      step();
      disp_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) step();
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_pd = '0;
      disp_ps1 = '0; disp_ps2 = '0; disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
      disp_imm = '0; disp_rob_idx = '0; wb_valid = '0; wb_tag = '0;
      rob_head = '0; flush = 1'b0; flush_rob_idx = '0; iss_ready = 1'b0;
      fork monitor(); join_none
      #2;
      check("por_count", 32'(count), 32'd0);
      check("por_disp_ready", 32'(disp_ready), 32'd1);
      check("por_iss_valid", 32'(iss_valid), 32'd0);
      step(); step();
      reset_n = 1'b1;

      // Asynchronous reset with three entries held
      for (int i = 0; i < 3; i++) dispatch(7'd20, 1'b0, 7'd1, 1'b1, 5'(i));
      check("pre_reset_count", 32'(count), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      check("async_count", 32'(count), 32'd0);
      check("async_iss_valid", 32'(iss_valid), 32'd0);
      check("async_disp_ready", 32'(disp_ready), 32'd1);
      check("async_iss_rob", 32'(iss_rob_idx), 32'd0);
      step();
      reset_n = 1'b1;

      // Fill to DEPTH, ninth uop ignored, then wake all and drain in age order
      for (int i = 0; i < 8; i++) dispatch(7'(30 + i), 1'b0, 7'd1, 1'b1, 5'(i));
      check("full_count", 32'(count), 32'd8);
      check("full_disp_ready", 32'(disp_ready), 32'd0);
      dispatch(7'd50, 1'b1, 7'd1, 1'b1, 5'd8);
      check("ninth_ignored", 32'(count), 32'd8);
      for (int j = 0; j < 4; j++) begin
         wb_valid = 2'b11;
         wb_tag   = {7'(31 + 2*j), 7'(30 + 2*j)};
         step();
      end
      wb_valid = '0;
      for (int i = 0; i < 8; i++) exp_q.push_back({5'(i), 7'(30 + i)});
      iss_ready = 1'b1;
      drain("fill_drain");
      check("fill_empty", 32'(count), 32'd0);
      iss_ready = 1'b0;

      // Age select across ROB wrap
      rob_head = 5'd30;
      dispatch(7'd2, 1'b1, 7'd3, 1'b1, 5'd31);
      dispatch(7'd4, 1'b1, 7'd3, 1'b1, 5'd2);
      dispatch(7'd6, 1'b1, 7'd3, 1'b1, 5'd0);
      @(negedge clk);
      check("age_held_valid", 32'(iss_valid), 32'd1);
      check("age_held_rob", 32'(iss_rob_idx), 32'd31);
      exp_q.push_back({5'd31, 7'd2});
      exp_q.push_back({5'd0, 7'd6});
      exp_q.push_back({5'd2, 7'd4});
      step();
      iss_ready = 1'b1;
      drain("age_drain");
      check("age_empty", 32'(count), 32'd0);
      rob_head = 5'd0;

      // Wakeup on port 1 issues exactly one cycle later
      dispatch(7'd9, 1'b0, 7'd5, 1'b1, 5'd4);
      exp_q.push_back({5'd4, 7'd9});
      wb_valid = 2'b10;
      wb_tag   = {7'd9, 7'd0};
      @(negedge clk);
      check("wake_cycle_n", 32'(iss_valid), 32'd0);
      step();
      wb_valid = '0;
      @(negedge clk);
      check("wake_cycle_n1", 32'(iss_valid), 32'd1);
      check("wake_ps1", 32'(iss_ps1), 32'd9);
      step();
      check("wake_empty", 32'(count), 32'd0);
      iss_ready = 1'b0;

      // Flush squashes younger entries and drops same-cycle dispatch
      dispatch(7'd2, 1'b1, 7'd3, 1'b1, 5'd3);
      dispatch(7'd4, 1'b1, 7'd3, 1'b1, 5'd5);
      dispatch(7'd6, 1'b1, 7'd3, 1'b1, 5'd7);
      @(negedge clk);
      check("preflush_valid", 32'(iss_valid), 32'd1);
      check("preflush_count", 32'(count), 32'd3);
      step();
      iss_ready     = 1'b1;
      flush         = 1'b1;
      flush_rob_idx = 5'd5;
      disp_valid    = 1'b1;
      disp_rob_idx  = 5'd9;
      disp_ps1_rdy  = 1'b1;
      disp_ps2_rdy  = 1'b1;
      @(negedge clk);
      check("flush_iss_valid", 32'(iss_valid), 32'd0);
      step();
      flush      = 1'b0;
      disp_valid = 1'b0;
      iss_ready  = 1'b0;
      @(negedge clk);
      check("flush_count", 32'(count), 32'd2);
      check("flush_oldest", 32'(iss_rob_idx), 32'd3);
      exp_q.push_back({5'd3, 7'd2});
      exp_q.push_back({5'd5, 7'd4});
      step();
      iss_ready = 1'b1;
      drain("flush_drain");
      check("flush_empty", 32'(count), 32'd0);

      // Same-cycle wakeup during dispatch
      wb_valid = 2'b01;
      wb_tag   = {7'd0, 7'd12};
`ifdef ISSUE_QUEUE_BYPASS_EN
      exp_q.push_back({5'd10, 7'd12});
      dispatch(7'd12, 1'b0, 7'd3, 1'b1, 5'd10);
      wb_valid = '0;
      @(negedge clk);
      check("bypass_issue", 32'(iss_valid), 32'd1);
      drain("bypass_drain");
`else
      dispatch(7'd12, 1'b0, 7'd3, 1'b1, 5'd10);
      wb_valid = '0;
      @(negedge clk);
      check("nobypass_wait", 32'(iss_valid), 32'd0);
      repeat (3) step();
      check("nobypass_still", 32'(iss_valid), 32'd0);
      check("nobypass_count", 32'(count), 32'd1);
      exp_q.push_back({5'd10, 7'd12});
      wb_valid = 2'b01;
      step();
      wb_valid = '0;
      drain("nobypass_drain");
`endif
      check("final_count", 32'(count), 32'd0);
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
